// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: parametrised UART receiver with OVERSAMPLE ticks per bit,
// 3-sample majority vote at mid-bit, optional parity, 1 or 2 stop bits, and a
// single-entry valid/ready output buffer with frame/parity/overrun status.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 internal_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);
  localparam int unsigned MID = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_M1   = TW'(MID - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID);
  localparam logic [TW-1:0] TICK_P1   = TW'(MID + 1);
  localparam logic [BW-1:0] BITS_DONE = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic                   r_samp0;
  logic                   r_samp1;
  logic                   w_bit;
  logic                   w_decide;
  logic                   w_tick_wrap;
  logic                   w_par_err;
  state_t                 r_state;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_ferr;
  logic                   r_perr;
  logic                   r_armed;
  logic                   r_done;

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_bit       = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);
  assign w_decide    = (r_tick == TICK_P1);
  assign w_tick_wrap = (r_tick == TICK_LAST);
  // Odd parity: error when data^p is 0; even parity: error when data^p is 1.
  assign w_par_err   = (PARITY == 1) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);

  // Metastability synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
  end

  // Capture the two early mid-bit samples; the third is rx_s at the decide tick.
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) begin
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (r_tick == TICK_M1)  r_samp0 <= w_rx_s;
      if (r_tick == TICK_MID) r_samp1 <= w_rx_s;
    end
  end

  // Frame FSM: start detect, bit timing, shifting, parity/stop checks, break guard.
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_armed   <= 1'b1;
      r_done    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_tick <= w_tick_wrap ? '0 : r_tick + TW'(1);
      case (r_state)
        S_IDLE: begin
          if (r_armed && !w_rx_s) begin
            // Detecting cycle counts as tick 0.
            r_state <= S_START;
            r_tick  <= TW'(1);
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            o_busy  <= 1'b1;
          end else if (!r_armed && w_rx_s) begin
            r_armed <= 1'b1;
          end
        end
        S_START: begin
          if (w_decide && w_bit) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            o_busy  <= 1'b0;
          end else if (w_tick_wrap) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_decide) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          if (w_tick_wrap && (r_bit_cnt == BITS_DONE)) begin
            r_bit_cnt <= '0;
            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_decide) r_perr <= w_par_err;
          if (w_tick_wrap) begin
            r_bit_cnt <= '0;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_decide) begin
            if (!w_bit) r_ferr <= 1'b1;
            if (r_bit_cnt == STOP_LAST) begin
              // Leave at the decision point so the next start edge is not missed.
              r_state <= S_IDLE;
              r_tick  <= '0;
              o_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (!w_bit) r_armed <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output buffer: load on completion if free or draining, else flag overrun.
  always_ff @(posedge internal_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (r_done && (!o_valid || i_ready)) begin
        o_data       <= r_shift;
        o_frame_err  <= r_ferr;
        o_parity_err <= r_perr;
        o_valid      <= 1'b1;
      end else begin
        if (r_done) o_overrun <= 1'b1;
        if (o_valid && i_ready) o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: an 8N1 instance and an 8E1 instance,
// directed frames on separate lines, monitor pops expected frames on each accept.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int unsigned OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       internal_clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ferr_a, ferr_b;
  logic       perr_a, perr_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks     = 0;
  int   failures   = 0;
  int   ovr_cnt_a  = 0;
  int   ovr_cnt_b  = 0;

  always #5 internal_clk = ~internal_clk;

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_dut_a (
    .internal_clk(internal_clk), .i_rst(rst), .i_rx(rx_a),
    .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a),
    .o_frame_err(ferr_a), .o_parity_err(perr_a), .o_overrun(ovr_a), .o_busy(busy_a)
  );

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_dut_b (
    .internal_clk(internal_clk), .i_rst(rst), .i_rx(rx_b),
    .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b),
    .o_frame_err(ferr_b), .o_parity_err(perr_b), .o_overrun(ovr_b), .o_busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    e.perr = pe;
    return e;
  endfunction

  // Inputs change 1 ns after the rising edge; monitor samples on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge internal_clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rx_a = b;
    else          rx_b = b;
  endtask

  task automatic send_bit(input int sel, input logic b);
    drive(sel, b);
    step(OS);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (has_par) send_bit(sel, pbit);
    send_bit(sel, stop);
  endtask

  // Monitor: every accepted frame must match the head of its queue.
  always @(negedge internal_clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_a: got data 0x%0h, expected no frame", data_a);
        end else begin
          e = q_a.pop_front();
          check("frame_a", 32'({data_a, ferr_a, perr_a}), 32'(e));
        end
      end
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_b: got data 0x%0h, expected no frame", data_b);
        end else begin
          e = q_b.pop_front();
          check("frame_b", 32'({data_b, ferr_b, perr_b}), 32'(e));
        end
      end
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  initial begin
    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    step(3);
    check("reset_outputs_a", 32'({data_a, valid_a, ferr_a, perr_a, ovr_a, busy_a}), 32'(0));
    check("reset_outputs_b", 32'({data_b, valid_b, ferr_b, perr_b, ovr_b, busy_b}), 32'(0));
    rst = 1'b0;
    step(2 * OS);

    // Clean 8N1 frame.
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    check("a5_drained", 32'(q_a.size()), 32'(0));

    // Short low glitch must abort in START.
    drive(0, 1'b0);
    step(4);
    drive(0, 1'b1);
    check("glitch_busy_high", 32'(busy_a), 32'(1));
    step(24);
    check("glitch_busy_low", 32'(busy_a), 32'(0));
    check("glitch_no_valid", 32'(valid_a), 32'(0));
    step(2 * OS);

    // Even parity: 0x07 has three ones, so p=0 is an error, p=1 is good.
    q_b.push_back(mk(8'h07, 1'b0, 1'b1));
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    send_bit(1, 1'b1);
    q_b.push_back(mk(8'h07, 1'b0, 1'b0));
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    send_bit(1, 1'b1);
    check("parity_drained", 32'(q_b.size()), 32'(0));

    // Break: stop bit low, line held low; exactly one errored frame, then rearm.
    q_a.push_back(mk(8'h00, 1'b1, 1'b0));
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(40 * OS);
    check("break_one_frame", 32'(q_a.size()), 32'(0));
    check("break_not_busy", 32'(busy_a), 32'(0));
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    check("rearm_drained", 32'(q_a.size()), 32'(0));

    // Overrun: consumer stalled, second frame dropped.
    ready_a = 1'b0;
    q_a.push_back(mk(8'h11, 1'b0, 1'b0));
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    check("ovr_valid_held", 32'(valid_a), 32'(1));
    check("ovr_data_held", 32'(data_a), 32'(8'h11));
    check("ovr_pulse_count", 32'(ovr_cnt_a), 32'(1));
    ready_a = 1'b1;
    step(4);
    check("ovr_valid_dropped", 32'(valid_a), 32'(0));
    check("ovr_drained", 32'(q_a.size()), 32'(0));

    // Reset mid-frame abandons 0xF0; 0x5A afterwards is clean.
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
    step(OS / 2);
    rst = 1'b1;
    drive(0, 1'b1);
    step(3);
    rst = 1'b0;
    step(2 * OS);
    check("rst_not_busy", 32'(busy_a), 32'(0));
    check("rst_no_valid", 32'(valid_a), 32'(0));
    q_a.push_back(mk(8'h5A, 1'b0, 1'b0));
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    step(OS);
    check("final_drained_a", 32'(q_a.size()), 32'(0));
    check("final_drained_b", 32'(q_b.size()), 32'(0));
    check("final_ovr_a", 32'(ovr_cnt_a), 32'(1));
    check("final_ovr_b", 32'(ovr_cnt_b), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
